// File: rtl/counter_param.sv
// Parametrised multi-mode counter: +STEP / -1 / +1 / parallel load, optional saturation,
// with registered carry/borrow flag, load flag and output-valid flag.
module counter_param #(
  parameter int WIDTH    = 4,
  parameter int STEP     = 3,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             load,
  output logic             rco,
  output logic             valid
);

  typedef enum logic [1:0] {
    MODE_STEP = 2'b00,
    MODE_DEC  = 2'b01,
    MODE_INC  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  localparam logic [WIDTH:0]   STEP_EXT = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0]   ONE_EXT  = (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_VAL  = '0;

  logic [WIDTH-1:0] q_q, q_d;
  logic             load_q, load_d;
  logic             rco_q, rco_d;
  logic             valid_q, valid_d;

  // Extended-width arithmetic: bit WIDTH carries the carry (add) or borrow (subtract).
  logic [WIDTH:0] sum_step;
  logic [WIDTH:0] sum_inc;
  logic [WIDTH:0] diff_dec;
  mode_e          mode_sel;

  assign sum_step = {1'b0, q_q} + STEP_EXT;
  assign sum_inc  = {1'b0, q_q} + ONE_EXT;
  assign diff_dec = {1'b0, q_q} - ONE_EXT;
  assign mode_sel = mode_e'(mode);

  always_comb begin
    q_d     = q_q;
    load_d  = 1'b0;
    rco_d   = 1'b0;
    valid_d = 1'b0;
    if (enable) begin
      valid_d = 1'b1;
      unique case (mode_sel)
        MODE_STEP: begin
          rco_d = sum_step[WIDTH];
          if (SATURATE && sum_step[WIDTH]) q_d = MAX_VAL;
          else                             q_d = sum_step[WIDTH-1:0];
        end
        MODE_DEC: begin
          rco_d = diff_dec[WIDTH];
          if (SATURATE && diff_dec[WIDTH]) q_d = MIN_VAL;
          else                             q_d = diff_dec[WIDTH-1:0];
        end
        MODE_INC: begin
          rco_d = sum_inc[WIDTH];
          if (SATURATE && sum_inc[WIDTH]) q_d = MAX_VAL;
          else                            q_d = sum_inc[WIDTH-1:0];
        end
        MODE_LOAD: begin
          q_d    = D;
          load_d = 1'b1;
        end
        default: q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q     <= '0;
      load_q  <= 1'b0;
      rco_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      q_q     <= q_d;
      load_q  <= load_d;
      rco_q   <= rco_d;
      valid_q <= valid_d;
    end
  end

  assign Q     = q_q;
  assign load  = load_q;
  assign rco   = rco_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_counter_param.sv
// Bench for counter_param: a wrapping and a saturating instance share one directed stimulus
// stream; an arithmetic model feeds expected queues and literal checks pin the model.
module tb_counter_param;

  localparam int W    = 4;
  localparam int STEP = 3;
  localparam int MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         enable = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [W-1:0] d_in = '0;

  logic [W-1:0] q_a, q_b;
  logic         load_a, load_b, rco_a, rco_b, valid_a, valid_b;

  int total = 0;
  int bad   = 0;

  logic [W+2:0] exp_a[$];
  logic [W+2:0] exp_b[$];
  logic [W-1:0] mq_a = '0;
  logic [W-1:0] mq_b = '0;
  bit           started = 1'b0;

  counter_param #(.WIDTH(W), .STEP(STEP), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .D(d_in),
    .Q(q_a), .load(load_a), .rco(rco_a), .valid(valid_a)
  );

  counter_param #(.WIDTH(W), .STEP(STEP), .SATURATE(1'b1)) u_sat (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .D(d_in),
    .Q(q_b), .load(load_b), .rco(rco_b), .valid(valid_b)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- model: returns {valid, load, rco, Q} after one edge ----------------
  function automatic logic [W+2:0] model(input logic [W-1:0] q, input logic r, input logic e,
                                         input logic [1:0] m, input logic [W-1:0] d,
                                         input bit sat);
    int nq;
    bit c, l;
    nq = int'(q);
    c  = 1'b0;
    l  = 1'b0;
    if (r) return '0;
    if (!e) return {3'b000, q};
    case (m)
      2'd0: begin
        nq = int'(q) + STEP;
        if (nq > MAXV) begin c = 1'b1; nq = sat ? MAXV : nq - (MAXV + 1); end
      end
      2'd1: begin
        if (q == 0) begin c = 1'b1; nq = sat ? 0 : MAXV; end
        else nq = int'(q) - 1;
      end
      2'd2: begin
        if (int'(q) == MAXV) begin c = 1'b1; nq = sat ? MAXV : 0; end
        else nq = int'(q) + 1;
      end
      default: begin nq = int'(d); l = 1'b1; end
    endcase
    return {1'b1, l, c, W'(nq)};
  endfunction

  always @(posedge clk) begin
    logic [W+2:0] ea, eb;
    if (reset) started = 1'b1;
    if (started) begin
      ea = model(mq_a, reset, enable, mode, d_in, 1'b0);
      eb = model(mq_b, reset, enable, mode, d_in, 1'b1);
      mq_a = ea[W-1:0];
      mq_b = eb[W-1:0];
      exp_a.push_back(ea);
      exp_b.push_back(eb);
    end
  end

  // ---------------- scoreboard: every negedge once outputs are defined ----------------
  always @(negedge clk) begin
    logic [W+2:0] e;
    if (exp_a.size() > 0) begin
      e = exp_a.pop_front();
      total++;
      if ({valid_a, load_a, rco_a, q_a} !== e) begin
        bad++;
        $display("FAIL sb_wrap t=%0t: got v=%b l=%b r=%b q=%0d want v=%b l=%b r=%b q=%0d",
                 $time, valid_a, load_a, rco_a, q_a, e[W+2], e[W+1], e[W], e[W-1:0]);
      end
    end
    if (exp_b.size() > 0) begin
      e = exp_b.pop_front();
      total++;
      if ({valid_b, load_b, rco_b, q_b} !== e) begin
        bad++;
        $display("FAIL sb_sat t=%0t: got v=%b l=%b r=%b q=%0d want v=%b l=%b r=%b q=%0d",
                 $time, valid_b, load_b, rco_b, q_b, e[W+2], e[W+1], e[W], e[W-1:0]);
      end
    end
  end

  // ---------------- driver and literal checks ----------------
  task automatic tick(input logic r, input logic e, input logic [1:0] m, input logic [W-1:0] d);
    reset  = r;
    enable = e;
    mode   = m;
    d_in   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Checks the wrapping instance against hand values {q, load, rco, valid}.
  task automatic chk_a(input string name, input int q, input bit l, input bit c, input bit v);
    chk({name, ".q"},     8'(q_a),     8'(q));
    chk({name, ".load"},  8'(load_a),  8'(l));
    chk({name, ".rco"},   8'(rco_a),   8'(c));
    chk({name, ".valid"}, 8'(valid_a), 8'(v));
  endtask

  task automatic chk_b(input string name, input int q, input bit l, input bit c);
    chk({name, ".q"},    8'(q_b),    8'(q));
    chk({name, ".load"}, 8'(load_b), 8'(l));
    chk({name, ".rco"},  8'(rco_b),  8'(c));
  endtask

  initial begin
    // reset state
    tick(1'b1, 1'b0, 2'd0, 4'd0);
    chk_a("reset_a", 0, 0, 0, 0);
    chk_b("reset_b", 0, 0, 0);

    // count up through the wrap: rco only on the cycle Q shows 0
    for (int i = 1; i <= 16; i++) begin
      tick(1'b0, 1'b1, 2'd2, 4'd0);
      chk_a($sformatf("inc_%0d", i), i % 16, 0, (i == 16), 1);
    end

    // +STEP with carry
    tick(1'b0, 1'b1, 2'd3, 4'd12); chk_a("ld12",   12, 1, 0, 1);
    tick(1'b0, 1'b1, 2'd0, 4'd0);  chk_a("step15", 15, 0, 0, 1);
    tick(1'b0, 1'b1, 2'd0, 4'd0);  chk_a("step2",   2, 0, 1, 1);
    tick(1'b0, 1'b1, 2'd3, 4'd13); chk_a("ld13",   13, 1, 0, 1);
    tick(1'b0, 1'b1, 2'd0, 4'd0);  chk_a("step0",   0, 0, 1, 1);

    // -1 with borrow
    tick(1'b0, 1'b1, 2'd3, 4'd1);  chk_a("ld1",     1, 1, 0, 1);
    tick(1'b0, 1'b1, 2'd1, 4'd0);  chk_a("dec0",    0, 0, 0, 1);
    tick(1'b0, 1'b1, 2'd1, 4'd0);  chk_a("dec15",  15, 0, 1, 1);
    tick(1'b0, 1'b1, 2'd1, 4'd0);  chk_a("dec14",  14, 0, 0, 1);

    // load then increment clears load
    tick(1'b0, 1'b1, 2'd3, 4'd9);  chk_a("ld9",     9, 1, 0, 1);
    tick(1'b0, 1'b1, 2'd2, 4'd0);  chk_a("inc10",  10, 0, 0, 1);

    // hold with enable low (mode=11 must not load), then reset mid-count wins over enable
    tick(1'b1, 1'b1, 2'd2, 4'd0);
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, 2'd2, 4'd0);
    chk_a("cnt6", 6, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 2'd3, 4'd5);
      chk_a($sformatf("hold_%0d", i), 6, 0, 0, 0);
    end
    tick(1'b0, 1'b1, 2'd2, 4'd0);  chk_a("cnt7", 7, 0, 0, 1);
    tick(1'b1, 1'b1, 2'd3, 4'd9);  chk_a("rst_mid", 0, 0, 0, 0);
    chk_b("rst_mid_b", 0, 0, 0);

    // saturation on the clamping instance; wrapping instance checked alongside
    tick(1'b0, 1'b1, 2'd3, 4'd14); chk_b("sat_ld14", 14, 1, 0);
    tick(1'b0, 1'b1, 2'd0, 4'd0);  chk_b("sat_up1", 15, 0, 1); chk_a("wrap_up1", 1, 0, 1, 1);
    tick(1'b0, 1'b1, 2'd0, 4'd0);  chk_b("sat_up2", 15, 0, 1); chk_a("wrap_up2", 4, 0, 0, 1);
    tick(1'b0, 1'b1, 2'd2, 4'd0);  chk_b("sat_inc", 15, 0, 1);
    tick(1'b0, 1'b1, 2'd3, 4'd0);  chk_b("sat_ld0",  0, 1, 0);
    tick(1'b0, 1'b1, 2'd1, 4'd0);  chk_b("sat_dec",  0, 0, 1); chk_a("wrap_dec", 15, 0, 1, 1);
    tick(1'b0, 1'b1, 2'd1, 4'd0);  chk_b("sat_dec2", 0, 0, 1);

    // mixed stream, checked by the scoreboard only
    for (int i = 0; i < 60; i++)
      tick(1'b0, 1'($urandom_range(0, 5) != 0), 2'($urandom_range(0, 3)),
           W'($urandom_range(0, MAXV)));

    tick(1'b0, 1'b0, 2'd0, 4'd0);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
